// File: rtl/sample_serializer_pkg.sv
// Shared definitions for the sample serializer: requester state encoding and
// frame-length helper used by the top and the bench.
package sample_serializer_pkg;

   typedef enum logic {
      REQ_IDLE = 1'b0,
      REQ_WAIT = 1'b1
   } req_state_t;

   // One stereo frame carries the same sample on both channels.
   function automatic int frame_bits(input int sample_w);
      return 2 * sample_w;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO: circular buffer, wrap-around pointers, push/pop
// ignored when full/empty, simultaneous push and pop keeps the level.
module sample_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == LVL_W'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sample_serializer.sv
// Requests samples from sine_reader, buffers them, and shifts each one out as
// a left-justified stereo frame (same sample on left and right) to the DAC.
module sample_serializer
   import sample_serializer_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   parameter  int SAMPLE_W   = 16,
   parameter  int BCLK_DIV   = 4,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   output logic                generate_next,
   input  logic                sample_ready,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                underflow,
   output logic [LVL_W-1:0]    fifo_level,
   output req_state_t          req_state
);

   localparam int FRAME_BITS = frame_bits(SAMPLE_W);
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int DIV_W      = $clog2(BCLK_DIV);

   req_state_t          state_q;
   req_state_t          state_d;
   logic                gen_d;
   logic                pending;
   logic [LVL_W:0]      committed;

   logic                fifo_full;
   logic                fifo_empty;
   logic [SAMPLE_W-1:0] fifo_data;
   logic                capture;

   logic                halted;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [SAMPLE_W-1:0] shreg;
   logic [SAMPLE_W-1:0] word_q;
   logic [SAMPLE_W-1:0] load_word;
   logic                run_tick;
   logic                wrap;
   logic                fall_evt;
   logic                frame_edge;
   logic                frame_start;

   assign req_state = state_q;
   assign pending   = (state_q == REQ_WAIT);
   assign committed = {1'b0, fifo_level} + {{LVL_W{1'b0}}, pending};
   assign capture   = sample_ready && !fifo_full;

   // Requester: one outstanding request, never over-commits the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= REQ_IDLE;
         generate_next <= 1'b0;
      end else begin
         state_q       <= state_d;
         generate_next <= gen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gen_d   = 1'b0;
      case (state_q)
         REQ_IDLE: begin
            if (enable && (committed < (LVL_W + 1)'(FIFO_DEPTH))) begin
               state_d = REQ_WAIT;
               gen_d   = 1'b1;
            end
         end
         REQ_WAIT: begin
            if (sample_ready) state_d = REQ_IDLE;
         end
         default: state_d = REQ_IDLE;
      endcase
   end

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (capture),
      .push_data (sample),
      .pop       (frame_start),
      .pop_data  (fifo_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Once started, the serializer runs until a frame boundary sees enable low.
   assign run_tick    = !halted || enable;
   assign wrap        = run_tick && (div_cnt == DIV_W'(BCLK_DIV - 1));
   assign fall_evt    = wrap && bclk;
   assign frame_edge  = fall_evt && (bit_cnt == '0);
   assign frame_start = frame_edge && enable;
   assign load_word   = fifo_empty ? '0 : fifo_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted    <= 1'b1;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         bclk      <= 1'b0;
         lrclk     <= 1'b0;
         sdata     <= 1'b0;
         underflow <= 1'b0;
         shreg     <= '0;
         word_q    <= '0;
      end else begin
         underflow <= frame_start && fifo_empty;
         if (run_tick) begin
            halted  <= 1'b0;
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) bclk <= ~bclk;
            if (fall_evt) begin
               if (frame_edge && !enable) begin
                  halted <= 1'b1;
                  lrclk  <= 1'b0;
                  sdata  <= 1'b0;
               end else begin
                  // bit_cnt is the index being sent; upper half is the right word.
                  lrclk   <= (bit_cnt >= BIT_W'(SAMPLE_W));
                  bit_cnt <= (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
                  if (frame_start) begin
                     word_q <= load_word;
                     sdata  <= load_word[SAMPLE_W-1];
                     shreg  <= load_word << 1;
                  end else if (bit_cnt == BIT_W'(SAMPLE_W)) begin
                     sdata <= word_q[SAMPLE_W-1];
                     shreg <= word_q << 1;
                  end else begin
                     sdata <= shreg[SAMPLE_W-1];
                     shreg <= shreg << 1;
                  end
               end
            end
         end
      end
   end

endmodule
